// File: rtl/pe_param.sv
// Parametrised systolic-array processing element: signed fixed-point saturating MAC
// with weight-stationary (double-buffered weights) and output-stationary dataflow modes.
module pe_param #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_mode_in,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  input  logic                  pe_psum_valid_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  output logic                  pe_psum_valid_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_sat_out
);

  localparam int W  = DATA_WIDTH;
  localparam int F  = FRAC_BITS;
  localparam int PW = 2 * DATA_WIDTH;

  // Round-half-up on the full product, then clamp to W bits; MSB of result flags a clamp.
  function automatic logic [W:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] half;
    logic signed [PW-1:0] r;
    logic signed [PW-1:0] maxv;
    logic signed [PW-1:0] minv;
    half       = '0;
    half[F-1]  = 1'b1;
    maxv       = '0;
    maxv[W-2:0] = '1;
    minv       = '1;
    minv[W-2:0] = '0;
    r = p + half;
    r = r >>> F;
    if (r > maxv)
      return {1'b1, maxv[W-1:0]};
    else if (r < minv)
      return {1'b1, minv[W-1:0]};
    else
      return {1'b0, r[W-1:0]};
  endfunction

  function automatic logic [W:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      return {1'b1, s[W], {(W-1){~s[W]}}};
    else
      return {1'b0, s[W-1:0]};
  endfunction

  logic [W-1:0] active_reg, active_next;
  logic [W-1:0] inactive_reg, inactive_next;
  logic [W-1:0] acc_reg, acc_next;
  logic         mode_reg;
  logic         sat_reg, sat_next;
  logic [W-1:0] psum_reg, psum_next;
  logic         psum_valid_reg, psum_valid_next;
  logic [W-1:0] weight_fwd_reg;
  logic         accept_fwd_reg;
  logic [W-1:0] input_fwd_reg;
  logic         valid_fwd_reg;
  logic         switch_fwd_reg;

  logic          mode_change;
  logic [W-1:0]  operand;
  logic [W-1:0]  acc_src;
  logic [PW-1:0] prod_full;
  logic [W-1:0]  prod_r;
  logic          prod_ovf;
  logic [W-1:0]  ws_sum;
  logic          ws_ovf;
  logic [W-1:0]  os_sum;
  logic          os_ovf;

  assign mode_change = (pe_mode_in != mode_reg);
  assign operand     = pe_mode_in ? pe_weight_in : active_reg;
  // A mode-change cycle sees an empty accumulator, so nothing from before the toggle leaks out.
  assign acc_src     = mode_change ? '0 : acc_reg;
  assign prod_full   = $signed({{W{pe_input_in[W-1]}}, pe_input_in}) *
                       $signed({{W{operand[W-1]}}, operand});
  assign {prod_ovf, prod_r} = round_sat(prod_full);
  assign {ws_ovf, ws_sum}   = add_sat(prod_r, pe_psum_in);
  assign {os_ovf, os_sum}   = add_sat(acc_src, prod_r);

  always_comb begin
    psum_next       = '0;
    psum_valid_next = 1'b0;
    acc_next        = acc_src;
    sat_next        = sat_reg;
    active_next     = active_reg;
    inactive_next   = inactive_reg;
    if (!pe_mode_in) begin
      if (pe_accept_w_in)
        inactive_next = pe_weight_in;
      if (pe_switch_in)
        active_next = inactive_reg;
      if (pe_valid_in) begin
        psum_next       = ws_sum;
        psum_valid_next = 1'b1;
        sat_next        = sat_reg | prod_ovf | ws_ovf;
      end
    end else begin
      if (pe_switch_in) begin
        psum_next       = pe_valid_in ? os_sum : acc_src;
        psum_valid_next = 1'b1;
        acc_next        = '0;
        if (pe_valid_in)
          sat_next = sat_reg | prod_ovf | os_ovf;
      end else if (pe_valid_in) begin
        if (!mode_change) begin
          acc_next = os_sum;
          sat_next = sat_reg | prod_ovf | os_ovf;
        end
      end else begin
        psum_next       = pe_psum_in;
        psum_valid_next = pe_psum_valid_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg     <= '0;
      inactive_reg   <= '0;
      acc_reg        <= '0;
      mode_reg       <= 1'b0;
      sat_reg        <= 1'b0;
      psum_reg       <= '0;
      psum_valid_reg <= 1'b0;
      weight_fwd_reg <= '0;
      accept_fwd_reg <= 1'b0;
      input_fwd_reg  <= '0;
      valid_fwd_reg  <= 1'b0;
      switch_fwd_reg <= 1'b0;
    end else begin
      active_reg     <= active_next;
      inactive_reg   <= inactive_next;
      acc_reg        <= acc_next;
      mode_reg       <= pe_mode_in;
      sat_reg        <= sat_next;
      psum_reg       <= psum_next;
      psum_valid_reg <= psum_valid_next;
      weight_fwd_reg <= pe_accept_w_in ? pe_weight_in : '0;
      accept_fwd_reg <= pe_accept_w_in;
      if (pe_valid_in)
        input_fwd_reg <= pe_input_in;
      valid_fwd_reg  <= pe_valid_in;
      switch_fwd_reg <= pe_switch_in;
    end
  end

  assign pe_psum_out       = psum_reg;
  assign pe_psum_valid_out = psum_valid_reg;
  assign pe_weight_out     = weight_fwd_reg;
  assign pe_accept_w_out   = accept_fwd_reg;
  assign pe_input_out      = input_fwd_reg;
  assign pe_valid_out      = valid_fwd_reg;
  assign pe_switch_out     = switch_fwd_reg;
  assign pe_sat_out        = sat_reg;

endmodule
